// File: rtl/fb_pc_unit_pkg.sv
// fb_pc_unit_pkg
//   Shared defaults and types for the Firebird program-counter unit.
//   FB_* localparams are the default build values for the top-level
//   parameters (32-bit PC, reset at 0, trap vector 0x100, byte step 4,
//   four-entry return-address stack).
package fb_pc_unit_pkg;

  localparam int          FB_XLEN       = 32;
  localparam logic [31:0] FB_RESET_ADDR = 32'h0000_0000;
  localparam logic [31:0] FB_TRAP_ADDR  = 32'h0000_0100;
  localparam int          FB_PC_STEP    = 4;
  localparam int          FB_RAS_DEPTH  = 4;

  // Which source wins the next-PC mux, highest priority first.
  typedef enum logic [2:0] {
    PC_SEL_TRAP,
    PC_SEL_REDIRECT,
    PC_SEL_HOLD,
    PC_SEL_POP,
    PC_SEL_SEQ
  } pc_sel_e;

endpackage

// File: rtl/fb_pc_unit_ras.sv
// fb_ras
//   Circular return-address stack.
//   ptr points at the next free slot; the top entry is ptr-1. Pushing when
//   full overwrites the oldest entry and count saturates at RAS_DEPTH.
// Ports
//   clk, pc_reset_n : clock and asynchronous active-low reset
//   clear           : drop all entries (trap)
//   push            : write push_data at ptr, advance ptr
//   pop             : retreat ptr (count must be non-zero)
//   replace         : overwrite the top entry with push_data
//   push_data       : data for push/replace
//   top             : current top entry (meaningless when count is 0)
//   count           : number of valid entries
module fb_ras #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       pc_reset_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       replace,
  input  logic [XLEN-1:0]            push_data,
  output logic [XLEN-1:0]            top,
  output logic [$clog2(RAS_DEPTH):0] count
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

  logic [XLEN-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   top_idx;

  // Power-of-two depth makes the pointer wrap for free.
  assign top_idx = ptr - PW'(1);
  assign top     = mem[top_idx];

  always_ff @(posedge clk or negedge pc_reset_n) begin
    if (!pc_reset_n) begin
      ptr   <= '0;
      count <= '0;
    end else if (clear) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr + PW'(1);
      if (count != FULL) count <= count + CW'(1);
    end else if (pop) begin
      ptr   <= top_idx;
      count <= count - CW'(1);
    end
  end

  // Storage is qualified by count, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[ptr] <= push_data;
    end else if (replace && !clear) begin
      mem[top_idx] <= push_data;
    end
  end

endmodule

// File: rtl/fb_pc_unit.sv
// fb_pc_unit
//   Program counter for the Firebird fetch path. Selects the next PC from
//   trap vector, branch redirect, hold, RAS-predicted return or sequential
//   increment, and registers it with one cycle of latency.
// Ports
//   clk, pc_reset_n : clock and asynchronous active-low reset
//   pc_stall        : hold the PC (hazard)
//   fetch_ready     : fetch stage accepts pc_out this cycle
//   redirect_valid  : resolved branch/jump, target on redirect_addr
//   trap_req        : exception/interrupt, vector to TRAP_ADDR
//   call_hint       : accepted PC is a call, push pc_out+STEP
//   ret_hint        : accepted PC is a return, pop RAS as next PC
//   pc_out/pc_valid : registered fetch address and its valid
//   pc_next         : combinational value pc_out takes at the next edge
//   ras_count       : valid RAS entries
module fb_pc_unit
  import fb_pc_unit_pkg::*;
#(
  parameter int              XLEN       = FB_XLEN,
  parameter logic [XLEN-1:0] RESET_ADDR = XLEN'(FB_RESET_ADDR),
  parameter logic [XLEN-1:0] TRAP_ADDR  = XLEN'(FB_TRAP_ADDR),
  parameter int              STEP       = FB_PC_STEP,
  parameter int              RAS_DEPTH  = FB_RAS_DEPTH
) (
  input  logic                       clk,
  input  logic                       pc_reset_n,
  input  logic                       pc_stall,
  input  logic                       fetch_ready,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_addr,
  input  logic                       trap_req,
  input  logic                       call_hint,
  input  logic                       ret_hint,
  output logic [XLEN-1:0]            pc_out,
  output logic                       pc_valid,
  output logic [XLEN-1:0]            pc_next,
  output logic [$clog2(RAS_DEPTH):0] ras_count
);

  logic            accept;
  logic            ras_nonempty;
  logic [XLEN-1:0] pc_seq;
  logic [XLEN-1:0] ras_top;
  logic            ras_clear;
  logic            ras_push;
  logic            ras_pop;
  logic            ras_replace;
  pc_sel_e         sel;

  assign accept       = pc_valid & fetch_ready & ~pc_stall;
  assign ras_nonempty = (ras_count != '0);
  // Modulo 2^XLEN: the top of the address space silently wraps to 0.
  assign pc_seq       = pc_out + XLEN'(STEP);

  always_comb begin
    sel = PC_SEL_SEQ;
    if (trap_req)                                   sel = PC_SEL_TRAP;
    else if (redirect_valid)                        sel = PC_SEL_REDIRECT;
    else if (!accept)                               sel = PC_SEL_HOLD;
    else if (ret_hint && !call_hint && ras_nonempty) sel = PC_SEL_POP;
  end

  always_comb begin
    pc_next     = pc_out;
    ras_clear   = 1'b0;
    ras_push    = 1'b0;
    ras_pop     = 1'b0;
    ras_replace = 1'b0;
    case (sel)
      PC_SEL_TRAP: begin
        pc_next   = TRAP_ADDR;
        ras_clear = 1'b1;
      end
      PC_SEL_REDIRECT: pc_next = redirect_addr;
      PC_SEL_HOLD:     pc_next = pc_out;
      PC_SEL_POP: begin
        pc_next = ras_top;
        ras_pop = 1'b1;
      end
      default: begin
        pc_next = pc_seq;
        // A call that is also a return swaps the top frame instead of growing.
        if (call_hint) begin
          if (ret_hint && ras_nonempty) ras_replace = 1'b1;
          else                          ras_push    = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge pc_reset_n) begin
    if (!pc_reset_n) begin
      pc_out   <= RESET_ADDR;
      pc_valid <= 1'b0;
    end else begin
      pc_out   <= pc_next;
      pc_valid <= 1'b1;
    end
  end

  fb_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk        (clk),
    .pc_reset_n (pc_reset_n),
    .clear      (ras_clear),
    .push       (ras_push),
    .pop        (ras_pop),
    .replace    (ras_replace),
    .push_data  (pc_seq),
    .top        (ras_top),
    .count      (ras_count)
  );

endmodule

// File: tb/tb_fb_pc_unit.sv
// tb_fb_pc_unit
//   Self-checking bench for fb_pc_unit with default parameters
//   (XLEN 32, RESET_ADDR 0, TRAP_ADDR 0x100, STEP 4, RAS_DEPTH 4).
//   Each row drives one cycle of inputs and pushes the expected pc_out and
//   ras_count; after the edge the entry is popped and compared.
module tb_fb_pc_unit;

  logic        clk = 1'b0;
  logic        pc_reset_n;
  logic        pc_stall;
  logic        fetch_ready;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        trap_req;
  logic        call_hint;
  logic        ret_hint;
  logic [31:0] pc_out;
  logic        pc_valid;
  logic [31:0] pc_next;
  logic [2:0]  ras_count;

  typedef struct {
    logic        stall;
    logic        ready;
    logic        redir;
    logic [31:0] addr;
    logic        trap;
    logic        call;
    logic        ret;
    logic [31:0] epc;
    logic [2:0]  ecnt;
  } row_t;

  typedef struct {
    logic [31:0] pc;
    logic [2:0]  cnt;
  } exp_t;

  row_t rows[$];
  exp_t exp_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  fb_pc_unit dut (
    .clk            (clk),
    .pc_reset_n     (pc_reset_n),
    .pc_stall       (pc_stall),
    .fetch_ready    (fetch_ready),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .trap_req       (trap_req),
    .call_hint      (call_hint),
    .ret_hint       (ret_hint),
    .pc_out         (pc_out),
    .pc_valid       (pc_valid),
    .pc_next        (pc_next),
    .ras_count      (ras_count)
  );

  function automatic row_t r(input logic stall, input logic ready, input logic redir,
                             input logic [31:0] addr, input logic trap, input logic call,
                             input logic ret, input logic [31:0] epc, input logic [2:0] ecnt);
    row_t x;
    x.stall = stall; x.ready = ready; x.redir = redir; x.addr = addr;
    x.trap = trap; x.call = call; x.ret = ret; x.epc = epc; x.ecnt = ecnt;
    return x;
  endfunction

  task automatic apply(input row_t x);
    exp_t e;
    pc_stall       = x.stall;
    fetch_ready    = x.ready;
    redirect_valid = x.redir;
    redirect_addr  = x.addr;
    trap_req       = x.trap;
    call_hint      = x.call;
    ret_hint       = x.ret;
    e.pc  = x.epc;
    e.cnt = x.ecnt;
    exp_q.push_back(e);
  endtask

  task automatic idle_inputs();
    pc_stall = 0; fetch_ready = 1; redirect_valid = 0; redirect_addr = '0;
    trap_req = 0; call_hint = 0; ret_hint = 0;
  endtask

  task automatic test_reset();
    exp_t e;
    idle_inputs();
    pc_reset_n = 1'b0;
    #12;
    total_cnt++;
    if ({pc_valid, ras_count, pc_out} !== {1'b0, 3'd0, 32'h0})
      $display("FAIL reset_state: got valid=%b cnt=%0d pc=%h expected valid=0 cnt=0 pc=00000000",
               pc_valid, ras_count, pc_out);
    else pass_cnt++;
    @(negedge clk);
    pc_reset_n = 1'b1;
    #1;
    total_cnt++;
    if (pc_valid !== 1'b0)
      $display("FAIL reset_release_valid: got %b expected 0", pc_valid);
    else pass_cnt++;
    rows.delete();
    rows.push_back(r(0,1,0,0,0,0,0, 32'h0, 0));
    rows.push_back(r(0,1,0,0,0,0,0, 32'h4, 0));
    rows.push_back(r(0,1,0,0,0,0,0, 32'h8, 0));
    rows.push_back(r(0,1,0,0,0,0,0, 32'hC, 0));
    foreach (rows[i]) begin
      apply(rows[i]);
      #1;
      total_cnt++;
      if (pc_next !== exp_q[0].pc)
        $display("FAIL reset_seq pc_next row %0d: got %h expected %h", i, pc_next, exp_q[0].pc);
      else pass_cnt++;
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total_cnt++;
      if ({pc_valid, ras_count, pc_out} !== {1'b1, e.cnt, e.pc})
        $display("FAIL reset_seq state row %0d: got valid=%b cnt=%0d pc=%h expected valid=1 cnt=%0d pc=%h",
                 i, pc_valid, ras_count, pc_out, e.cnt, e.pc);
      else pass_cnt++;
    end
  endtask

  task automatic test_stall_redirect();
    exp_t e;
    rows.delete();
    rows.push_back(r(0,1,1,32'h8, 0,0,0, 32'h8,  0));
    rows.push_back(r(1,1,0,32'h0, 0,0,0, 32'h8,  0));
    rows.push_back(r(1,1,0,32'h0, 0,0,0, 32'h8,  0));
    rows.push_back(r(1,1,0,32'h0, 0,0,0, 32'h8,  0));
    rows.push_back(r(1,1,1,32'h40,0,0,0, 32'h40, 0));
    rows.push_back(r(0,1,0,32'h0, 0,0,0, 32'h44, 0));
    rows.push_back(r(0,0,0,32'h0, 0,1,0, 32'h44, 0));
    rows.push_back(r(0,1,0,32'h0, 0,0,0, 32'h48, 0));
    foreach (rows[i]) begin
      apply(rows[i]);
      #1;
      total_cnt++;
      if (pc_next !== exp_q[0].pc)
        $display("FAIL stall pc_next row %0d: got %h expected %h", i, pc_next, exp_q[0].pc);
      else pass_cnt++;
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total_cnt++;
      if ({pc_valid, ras_count, pc_out} !== {1'b1, e.cnt, e.pc})
        $display("FAIL stall state row %0d: got valid=%b cnt=%0d pc=%h expected valid=1 cnt=%0d pc=%h",
                 i, pc_valid, ras_count, pc_out, e.cnt, e.pc);
      else pass_cnt++;
    end
  endtask

  task automatic test_trap();
    exp_t e;
    rows.delete();
    rows.push_back(r(0,1,0,32'h0, 0,1,0, 32'h4C,  1));
    rows.push_back(r(0,1,1,32'h80,1,1,0, 32'h100, 0));
    rows.push_back(r(1,0,0,32'h0, 0,0,0, 32'h100, 0));
    rows.push_back(r(0,1,0,32'h0, 0,0,0, 32'h104, 0));
    foreach (rows[i]) begin
      apply(rows[i]);
      #1;
      total_cnt++;
      if (pc_next !== exp_q[0].pc)
        $display("FAIL trap pc_next row %0d: got %h expected %h", i, pc_next, exp_q[0].pc);
      else pass_cnt++;
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total_cnt++;
      if ({pc_valid, ras_count, pc_out} !== {1'b1, e.cnt, e.pc})
        $display("FAIL trap state row %0d: got valid=%b cnt=%0d pc=%h expected valid=1 cnt=%0d pc=%h",
                 i, pc_valid, ras_count, pc_out, e.cnt, e.pc);
      else pass_cnt++;
    end
  endtask

  task automatic test_call_ret();
    exp_t e;
    rows.delete();
    rows.push_back(r(0,1,1,32'h10, 0,0,0, 32'h10,  0));
    rows.push_back(r(0,1,0,32'h0,  0,1,0, 32'h14,  1));
    rows.push_back(r(0,1,0,32'h0,  0,0,0, 32'h18,  1));
    rows.push_back(r(0,1,1,32'h200,0,0,1, 32'h200, 1));
    rows.push_back(r(0,1,0,32'h0,  0,0,1, 32'h14,  0));
    rows.push_back(r(0,1,0,32'h0,  0,0,1, 32'h18,  0));
    rows.push_back(r(1,1,0,32'h0,  0,1,0, 32'h18,  0));
    rows.push_back(r(0,1,0,32'h0,  0,1,0, 32'h1C,  1));
    rows.push_back(r(0,1,0,32'h0,  0,1,1, 32'h20,  1));
    rows.push_back(r(0,1,0,32'h0,  0,0,1, 32'h20,  0));
    foreach (rows[i]) begin
      apply(rows[i]);
      #1;
      total_cnt++;
      if (pc_next !== exp_q[0].pc)
        $display("FAIL call_ret pc_next row %0d: got %h expected %h", i, pc_next, exp_q[0].pc);
      else pass_cnt++;
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total_cnt++;
      if ({pc_valid, ras_count, pc_out} !== {1'b1, e.cnt, e.pc})
        $display("FAIL call_ret state row %0d: got valid=%b cnt=%0d pc=%h expected valid=1 cnt=%0d pc=%h",
                 i, pc_valid, ras_count, pc_out, e.cnt, e.pc);
      else pass_cnt++;
    end
  endtask

  task automatic test_ras_overflow();
    exp_t e;
    rows.delete();
    rows.push_back(r(0,1,1,32'h0, 0,0,0, 32'h0,  0));
    rows.push_back(r(0,1,0,32'h0, 0,1,0, 32'h4,  1));
    rows.push_back(r(0,1,1,32'h10,0,0,0, 32'h10, 1));
    rows.push_back(r(0,1,0,32'h0, 0,1,0, 32'h14, 2));
    rows.push_back(r(0,1,1,32'h20,0,0,0, 32'h20, 2));
    rows.push_back(r(0,1,0,32'h0, 0,1,0, 32'h24, 3));
    rows.push_back(r(0,1,1,32'h30,0,0,0, 32'h30, 3));
    rows.push_back(r(0,1,0,32'h0, 0,1,0, 32'h34, 4));
    rows.push_back(r(0,1,1,32'h40,0,0,0, 32'h40, 4));
    rows.push_back(r(0,1,0,32'h0, 0,1,0, 32'h44, 4));
    rows.push_back(r(0,1,0,32'h0, 0,0,1, 32'h44, 3));
    rows.push_back(r(0,1,0,32'h0, 0,0,1, 32'h34, 2));
    rows.push_back(r(0,1,0,32'h0, 0,0,1, 32'h24, 1));
    rows.push_back(r(0,1,0,32'h0, 0,0,1, 32'h14, 0));
    rows.push_back(r(0,1,0,32'h0, 0,0,1, 32'h18, 0));
    foreach (rows[i]) begin
      apply(rows[i]);
      #1;
      total_cnt++;
      if (pc_next !== exp_q[0].pc)
        $display("FAIL ras_overflow pc_next row %0d: got %h expected %h", i, pc_next, exp_q[0].pc);
      else pass_cnt++;
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total_cnt++;
      if ({pc_valid, ras_count, pc_out} !== {1'b1, e.cnt, e.pc})
        $display("FAIL ras_overflow state row %0d: got valid=%b cnt=%0d pc=%h expected valid=1 cnt=%0d pc=%h",
                 i, pc_valid, ras_count, pc_out, e.cnt, e.pc);
      else pass_cnt++;
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    rows.delete();
    rows.push_back(r(0,1,1,32'hFFFF_FFFC,0,0,0, 32'hFFFF_FFFC, 0));
    rows.push_back(r(0,1,0,32'h0,        0,0,0, 32'h0,         0));
    rows.push_back(r(0,1,1,32'hFFFF_FFFC,0,0,0, 32'hFFFF_FFFC, 0));
    rows.push_back(r(0,1,0,32'h0,        0,1,0, 32'h0,         1));
    rows.push_back(r(0,1,1,32'h300,      0,0,0, 32'h300,       1));
    rows.push_back(r(0,1,0,32'h0,        0,0,1, 32'h0,         0));
    rows.push_back(r(0,1,0,32'h0,        0,1,0, 32'h4,         1));
    foreach (rows[i]) begin
      apply(rows[i]);
      #1;
      total_cnt++;
      if (pc_next !== exp_q[0].pc)
        $display("FAIL wrap pc_next row %0d: got %h expected %h", i, pc_next, exp_q[0].pc);
      else pass_cnt++;
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total_cnt++;
      if ({pc_valid, ras_count, pc_out} !== {1'b1, e.cnt, e.pc})
        $display("FAIL wrap state row %0d: got valid=%b cnt=%0d pc=%h expected valid=1 cnt=%0d pc=%h",
                 i, pc_valid, ras_count, pc_out, e.cnt, e.pc);
      else pass_cnt++;
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    idle_inputs();
    // pc_out=4, ras_count=1 here; pull reset between clock edges.
    #3;
    pc_reset_n = 1'b0;
    #1;
    total_cnt++;
    if ({pc_valid, ras_count, pc_out} !== {1'b0, 3'd0, 32'h0})
      $display("FAIL async_reset: got valid=%b cnt=%0d pc=%h expected valid=0 cnt=0 pc=00000000",
               pc_valid, ras_count, pc_out);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if ({pc_valid, ras_count, pc_out} !== {1'b0, 3'd0, 32'h0})
      $display("FAIL async_reset_held: got valid=%b cnt=%0d pc=%h expected valid=0 cnt=0 pc=00000000",
               pc_valid, ras_count, pc_out);
    else pass_cnt++;
    @(negedge clk);
    pc_reset_n = 1'b1;
    rows.delete();
    rows.push_back(r(0,1,0,32'h0,0,0,1, 32'h0, 0));
    rows.push_back(r(0,1,0,32'h0,0,0,1, 32'h4, 0));
    foreach (rows[i]) begin
      apply(rows[i]);
      #1;
      total_cnt++;
      if (pc_next !== exp_q[0].pc)
        $display("FAIL async_reset pc_next row %0d: got %h expected %h", i, pc_next, exp_q[0].pc);
      else pass_cnt++;
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total_cnt++;
      if ({pc_valid, ras_count, pc_out} !== {1'b1, e.cnt, e.pc})
        $display("FAIL async_reset state row %0d: got valid=%b cnt=%0d pc=%h expected valid=1 cnt=%0d pc=%h",
                 i, pc_valid, ras_count, pc_out, e.cnt, e.pc);
      else pass_cnt++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far",
             pass_cnt, total_cnt);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stall_redirect();
    test_trap();
    test_call_ret();
    test_ras_overflow();
    test_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
